// File: rtl/regfile_access_ctrl.sv
// Command-driven initiator for the register bank: reads two operands,
// computes an ALU result and writes it back, or clears the whole bank.
module regfile_access_ctrl #(
  parameter int N = 5,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [N-1:0] cmd_rs1,
  input  logic [N-1:0] cmd_rs2,
  input  logic [N-1:0] cmd_rd,
  output logic [N-1:0] rf_addr_rs1,
  output logic [N-1:0] rf_addr_rs2,
  input  logic [W-1:0] rf_rs1,
  input  logic [W-1:0] rf_rs2,
  output logic [N-1:0] rf_addr_rd,
  output logic [W-1:0] rf_data_in,
  output logic         rf_we,
  output logic         done,
  output logic [W-1:0] result,
  output logic         flag_z,
  output logic         flag_c
);

  localparam int SW = (W > 1) ? $clog2(W) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_CLR = 3'b111;

  localparam logic [N-1:0] ADDR_ONE  = 1;
  localparam logic [N-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, CLEAR} state_t;

  state_t         state;
  logic [2:0]     op_q;
  logic [N-1:0]   rd_q;
  logic [W-1:0]   opa;
  logic [W-1:0]   opb;
  logic [W-1:0]   alu_res;
  logic           alu_c;

  // ALU on the captured operands; carry only meaningful for ADD/SUB
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_q)
      OP_ADD:  {alu_c, alu_res} = {1'b0, opa} + {1'b0, opb};
      OP_SUB:  begin
        alu_res = opa - opb;
        alu_c   = (opa < opb);
      end
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_SLL:  alu_res = opa << opb[SW-1:0];
      OP_MOV:  alu_res = opa;
      default: alu_res = '0;
    endcase
  end

  // Command FSM; every bank-facing output and status flag is registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      op_q        <= '0;
      rd_q        <= '0;
      opa         <= '0;
      opb         <= '0;
      rf_addr_rs1 <= '0;
      rf_addr_rs2 <= '0;
      rf_addr_rd  <= '0;
      rf_data_in  <= '0;
      rf_we       <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      flag_z      <= 1'b0;
      flag_c      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rf_we <= 1'b0;
          done  <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            op_q      <= cmd_op;
            rd_q      <= cmd_rd;
            if (cmd_op == OP_CLR) begin
              // First clear write is issued straight from acceptance, at address 1
              state      <= CLEAR;
              rf_we      <= 1'b1;
              rf_addr_rd <= ADDR_ONE;
              rf_data_in <= '0;
              if (ADDR_ONE == ADDR_LAST) begin
                done   <= 1'b1;
                result <= '0;
                flag_z <= 1'b1;
                flag_c <= 1'b0;
              end
            end else begin
              state       <= READ;
              rf_addr_rs1 <= cmd_rs1;
              rf_addr_rs2 <= cmd_rs2;
            end
          end
        end
        READ: begin
          opa   <= rf_rs1;
          opb   <= rf_rs2;
          state <= EXEC;
        end
        EXEC: begin
          result     <= alu_res;
          flag_z     <= (alu_res == '0);
          flag_c     <= alu_c;
          rf_addr_rd <= rd_q;
          rf_data_in <= alu_res;
          rf_we      <= (rd_q != '0);
          done       <= 1'b1;
          state      <= WRITE;
        end
        WRITE: begin
          rf_we     <= 1'b0;
          done      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        CLEAR: begin
          if (rf_addr_rd == ADDR_LAST) begin
            rf_we     <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            rf_addr_rd <= rf_addr_rd + ADDR_ONE;
            if (rf_addr_rd == ADDR_LAST - ADDR_ONE) begin
              done   <= 1'b1;
              result <= '0;
              flag_z <= 1'b1;
              flag_c <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench: behavioural register bank plus an arithmetic
// reference model of the command set, directed cases then random commands.
module tb_regfile_access_ctrl;

  localparam int N    = 5;
  localparam int W    = 8;
  localparam int NREG = 1 << N;
  localparam int DMOD = 1 << W;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [N-1:0] cmd_rs1;
  logic [N-1:0] cmd_rs2;
  logic [N-1:0] cmd_rd;
  logic [N-1:0] rf_addr_rs1;
  logic [N-1:0] rf_addr_rs2;
  logic [W-1:0] rf_rs1;
  logic [W-1:0] rf_rs2;
  logic [N-1:0] rf_addr_rd;
  logic [W-1:0] rf_data_in;
  logic         rf_we;
  logic         done;
  logic [W-1:0] result;
  logic         flag_z;
  logic         flag_c;

  regfile_access_ctrl #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
    .rf_addr_rs1(rf_addr_rs1), .rf_addr_rs2(rf_addr_rs2),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_addr_rd(rf_addr_rd), .rf_data_in(rf_data_in), .rf_we(rf_we),
    .done(done), .result(result), .flag_z(flag_z), .flag_c(flag_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register bank; the bench preloads it through the poke port
  logic [W-1:0] bank [NREG];
  logic         poke_en;
  logic [N-1:0] poke_addr;
  logic [W-1:0] poke_data;

  always @(posedge clk) begin
    if (rf_we) bank[rf_addr_rd] <= rf_data_in;
    if (poke_en) bank[poke_addr] <= poke_data;
  end

  assign rf_rs1 = (rf_addr_rs1 == '0) ? '0 : bank[rf_addr_rs1];
  assign rf_rs2 = (rf_addr_rs2 == '0) ? '0 : bank[rf_addr_rs2];

  int model [NREG];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int rd_model(input int a);
    return (a == 0) ? 0 : model[a];
  endfunction

  task automatic ref_op(input int op, input int a, input int b, output int res, output int c);
    int s;
    c = 0;
    case (op)
      0: begin s = a + b; res = s % DMOD; c = (s >= DMOD) ? 1 : 0; end
      1: begin res = (a - b + DMOD) % DMOD; c = (a < b) ? 1 : 0; end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = (a * (1 << (b % W))) % DMOD;
      6: res = a;
      default: res = 0;
    endcase
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge
  task automatic poke(input int a, input int d);
    poke_addr = a[N-1:0];
    poke_data = d[W-1:0];
    poke_en   = 1'b1;
    @(posedge clk);
    #1 poke_en = 1'b0;
    @(negedge clk);
    model[a] = d % DMOD;
  endtask

  // Present a command and wait for acceptance; fields are scrambled afterwards
  task automatic send(input int op, input int rs1, input int rs2, input int rd, input bit hold);
    bit ready_seen;
    cmd_op    = op[2:0];
    cmd_rs1   = rs1[N-1:0];
    cmd_rs2   = rs2[N-1:0];
    cmd_rd    = rd[N-1:0];
    cmd_valid = 1'b1;
    ready_seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (cmd_ready) begin
        ready_seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ready_seen) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
    cmd_op  = 3'($urandom);
    cmd_rs1 = N'($urandom);
    cmd_rs2 = N'($urandom);
    cmd_rd  = N'($urandom);
  endtask

  // Watch one accepted command to completion and compare with the model
  task automatic observe(input int op, input int rs1, input int rs2, input int rd);
    int a, b, res, c, lat, writes, bad_seq, busy_ready;
    a = rd_model(rs1);
    b = rd_model(rs2);
    ref_op(op, a, b, res, c);
    lat = 0; writes = 0; bad_seq = 0; busy_ready = 0;
    for (int cyc = 1; cyc <= 64; cyc++) begin
      @(negedge clk);
      if (cmd_ready) busy_ready++;
      if (rf_we) begin
        writes++;
        if (op == 7 && (int'(rf_addr_rd) != writes || rf_data_in != '0)) bad_seq++;
      end
      if (done) begin
        lat = cyc;
        break;
      end
    end
    check("busy_ready", busy_ready, 0);
    if (op == 7) begin
      check("clr_latency", lat, NREG - 1);
      check("clr_writes", writes, NREG - 1);
      check("clr_sequence", bad_seq, 0);
      check("clr_result", result, 0);
      check("clr_flag_z", flag_z, 1);
      check("clr_flag_c", flag_c, 0);
      for (int i = 0; i < NREG; i++) model[i] = 0;
    end else begin
      check("latency", lat, 3);
      check("writes", writes, (rd != 0) ? 1 : 0);
      if (rd != 0) begin
        check("wr_addr", rf_addr_rd, rd);
        check("wr_data", rf_data_in, res);
        model[rd] = res;
      end
      check("result", result, res);
      check("flag_z", flag_z, (res == 0) ? 1 : 0);
      check("flag_c", flag_c, c);
    end
    @(negedge clk);
    check("done_pulse", done, 0);
    check("we_after", rf_we, 0);
    check("ready_after", cmd_ready, 1);
  endtask

  task automatic run(input int op, input int rs1, input int rs2, input int rd);
    send(op, rs1, rs2, rd, 1'b0);
    observe(op, rs1, rs2, rd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen7, late_we, bad;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    for (int i = 0; i < NREG; i++) model[i] = 0;
    repeat (2) @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_we", rf_we, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_flags", {flag_z, flag_c}, 0);
    check("rst_addrs", {rf_addr_rs1, rf_addr_rs2, rf_addr_rd}, 0);
    check("rst_data", rf_data_in, 0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 1; i < NREG; i++) poke(i, int'($urandom_range(1, 255)));

    // Reset in the middle of a clear: writes stop at once, remaining regs untouched
    send(7, 0, 0, 0, 1'b0);
    seen7 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rf_we && rf_addr_rd == 7) begin
        seen7 = 1;
        break;
      end
    end
    check("clr_reach7", seen7, 1);
    #1 rst = 1'b1;
    #1;
    check("midrst_we", rf_we, 0);
    check("midrst_ready", cmd_ready, 1);
    check("midrst_result", result, 0);
    check("midrst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i < 7; i++) model[i] = 0;
    late_we = 0;
    repeat (10) begin
      @(negedge clk);
      if (rf_we) late_we++;
    end
    check("midrst_nowrites", late_we, 0);
    bad = 0;
    for (int i = 1; i < NREG; i++) if (int'(bank[i]) != model[i]) bad++;
    check("midrst_bank", bad, 0);

    // ADD with carry
    poke(1, 'hF0); poke(2, 'h20);
    run(0, 1, 2, 3);
    // SUB equal and SUB borrow
    poke(1, 'h05); poke(2, 'h05);
    run(1, 1, 2, 4);
    poke(1, 'h03);
    run(1, 1, 2, 4);
    // SLL with shift amount wrapped to low bits, rd = 0 suppresses the write
    poke(1, 'h81); poke(2, 'h09);
    run(5, 1, 2, 0);
    // rd equal to a source, rs1 == rs2
    run(2, 3, 3, 3);

    // Back-to-back: ADD writes r1, XOR held valid re-reads the new r1
    poke(5, 'h50); poke(6, 'h5A); poke(2, 'hFF);
    send(0, 5, 6, 1, 1'b1);
    observe(0, 5, 6, 1);
    send(4, 1, 2, 1, 1'b0);
    observe(4, 1, 2, 1);
    check("b2b_r1", bank[1], 'h55);

    // Full clear, then read back through the bank and through a MOV
    run(7, 0, 0, 0);
    bad = 0;
    for (int i = 1; i < NREG; i++) if (bank[i] != '0) bad++;
    check("clr_bank_zero", bad, 0);
    run(6, 31, 0, 9);

    // Random commands against the model
    for (int t = 0; t < 60; t++) begin
      int op;
      if ($urandom_range(0, 3) == 0) begin
        poke(int'($urandom_range(1, NREG - 1)), int'($urandom_range(0, 255)));
        poke(int'($urandom_range(1, NREG - 1)), int'($urandom_range(0, 255)));
      end
      op = ($urandom_range(0, 14) == 0) ? 7 : int'($urandom_range(0, 6));
      run(op, int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, NREG - 1)),
          int'($urandom_range(0, NREG - 1)));
    end
    bad = 0;
    for (int i = 1; i < NREG; i++) if (int'(bank[i]) != model[i]) bad++;
    check("final_bank", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Command-driven initiator for the register bank's read/write interface.
- Accepts one ALU-style command per handshake and drives the bank's two read addresses.
- Captures the returned operands, computes the result, and issues a single write-back (rd, data, WE).
- Also provides a bulk-clear command that zeroes every register by sequential writes. Sits between the lab's command source (switches/test FSM) and the register bank.

Parameters:
N, 5, register address width (2^N registers; register 0 reads as zero)
W, 8, data width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_op  in  3  operation code
cmd_rs1  in  N  source address 1
cmd_rs2  in  N  source address 2
cmd_rd  in  N  destination address
rf_addr_rs1  out  N  bank read address 1
rf_addr_rs2  out  N  bank read address 2
rf_rs1  in  W  bank read data 1 (combinational from rf_addr_rs1)
rf_rs2  in  W  bank read data 2 (combinational from rf_addr_rs2)
rf_addr_rd  out  N  bank write address
rf_data_in  out  W  bank write data
rf_we  out  1  bank write enable
done  out  1  one-cycle pulse when a command completes
result  out  W  last computed result, held
flag_z  out  1  result == 0, held
flag_c  out  1  ADD carry-out / SUB borrow, held

Behaviour:
- Reset values: state IDLE, cmd_ready=1, all rf_* outputs 0, rf_we=0, done=0, result=0, flag_z=0, flag_c=0.
- Reset mid-command drops the command; no write is issued. Commands are ignored while rst=1.
- Opcodes:
  - 000 ADD, 001 SUB (rs1-rs2), 010 AND, 011 OR, 100 XOR.
  - 101 SLL: rs1 shifted left by rs2[$clog2(W)-1:0].
  - 110 MOV: rd=rs1.
  - 111 CLR: rs1/rs2/rd fields ignored.
- Arithmetic: unsigned, results truncated to W bits.
  - flag_c = bit W of the ADD sum; for SUB, flag_c = 1 iff rs1<rs2.
  - flag_c = 0 for all logic/shift/MOV ops.
- FSM states: IDLE, READ, EXEC, WRITE, CLEAR.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch op/rs1/rs2/rd. Go to CLEAR if op=111, else READ.
- READ (1 cycle):
  - rf_addr_rs1/rs2 driven from the latched fields. These are registered outputs, valid from the first cycle after acceptance.
  - rf_rs1/rf_rs2 are sampled into operand registers at the end of the cycle.
- EXEC (1 cycle): compute from the operand registers; register result, flag_z, flag_c.
- WRITE (1 cycle):
  - rf_we=1, rf_addr_rd=latched rd, rf_data_in=result, done=1.
  - Then go to IDLE.
  - If rd==0, rf_we stays 0 but done, result and flags still update.
- Latency: acceptance at edge k gives rf_we/done high during cycle k+3. cmd_ready is low for 3 cycles, so peak throughput is 1 command per 4 cycles.
- CLEAR:
  - A counter starts at 1. Each cycle: rf_we=1, rf_addr_rd=counter, rf_data_in=0, counter++.
  - On counter == 2^N-1: done=1 in the same cycle, then go to IDLE. Total 2^N-1 write cycles; address 0 is never written.
  - On completion: result=0, flag_z=1, flag_c=0.
- Handshake rules:
  - cmd_* inputs are only sampled on acceptance; changes during a busy period are ignored.
  - cmd_valid held high across completion is accepted again in the IDLE cycle following WRITE/CLEAR.
- Same-address operands:
  - rs1==rs2 is legal.
  - rd equal to rs1/rs2 is legal: the read completes in READ, before WRITE.
- rf_we is 0 in every state other than WRITE (rd≠0) and CLEAR.

Test Plan:
- Reset then idle: after rst pulse mid-CLEAR (counter=7) → rf_we=0 immediately, cmd_ready=1, result=0, no further writes.
- ADD with carry: bank r1=0xF0, r2=0x20; cmd ADD rs1=1 rs2=2 rd=3 → cycle k+3: rf_we=1, rf_addr_rd=3, rf_data_in=0x10, flag_c=1, flag_z=0, done=1.
- SUB borrow/zero: r1=0x05,r2=0x05 SUB rd=4 → data 0x00, flag_z=1, flag_c=0; r1=0x03,r2=0x05 → data 0xFE, flag_c=1.
- SLL and rd=0: r1=0x81, r2=0x09, SLL rd=0 → result=0x02, done=1, rf_we never asserted.
- Back-to-back: cmd_valid held with ADD then XOR (r1=0xAA,r2=0xFF, rd=1) → second acceptance exactly 4 cycles after the first, XOR writes 0x55 to r1; operands of the second command read the updated r1.
- CLR: N=5 → 31 consecutive rf_we cycles with addresses 1..31, data 0, done on address 31; subsequent reads of r1..r31 return 0.
